// File: rtl/column_drain_reader_if.sv
// column_drain_reader_if: valid/ready word stream from the column drain reader to the chip serializer
interface column_drain_reader_if #(
  parameter int W = 27
) ();
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
  modport master (output out_data, output out_valid, input out_ready);
  modport slave (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/column_drain_reader.sv
// column_drain_reader: freezes the matrix, drains hit columns lowest index first onto a valid/ready stream; define READOUT_TIMESTAMP_EN to prefix words with the freeze-cycle BCID
module column_drain_reader #(
  parameter int NCOL     = 56,
  parameter int DATA_W   = 21,
  parameter int COL_W    = 6,
  parameter int BCID_W   = 6,
  parameter int FRZ_DLY  = 2,
  parameter int READ_LEN = 2,
  parameter int TOK_DLY  = 2
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     EN,
  input  logic [NCOL-1:0]          nTOK,
  input  logic [NCOL*DATA_W-1:0]   Data,
  output logic [NCOL-1:0]          Read,
  output logic [NCOL-1:0]          FREEZE,
  output logic [BCID_W-1:0]        BCID,
  output logic                     busy,
  column_drain_reader_if.master    dout
);
  typedef enum logic [2:0] {IDLE, FRZ, SEL, RD, PUSH, GAP, UNFRZ} state_t;
  localparam logic [7:0] LAST_F = 8'(FRZ_DLY - 1);
  localparam logic [7:0] LAST_R = 8'(READ_LEN - 1);
  localparam logic [7:0] LAST_T = 8'(TOK_DLY - 1);
  state_t            state;
  logic [NCOL-1:0]   tok_q;
  logic [BCID_W-1:0] bin, bin_nxt;
  logic [COL_W-1:0]  col, lo_col;
  logic [DATA_W-1:0] col_data;
  logic [7:0]        cnt;
  logic              frz, any_hit;
`ifdef READOUT_TIMESTAMP_EN
  logic [BCID_W-1:0] bcid_frz;
`endif
  assign FREEZE   = {NCOL{frz}};
  assign bin_nxt  = bin + 1'b1;
  assign any_hit  = ~&tok_q;
  assign col_data = Data[col*DATA_W +: DATA_W];
  // lowest-index column still presenting a token
  always_comb begin
    lo_col = '0;
    for (int i = NCOL - 1; i >= 0; i--) if (!tok_q[i]) lo_col = COL_W'(i);
  end
  // token sampling and free-running Gray timestamp (BCID always equals gray(bin))
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      tok_q <= '1;
      bin   <= '0;
      BCID  <= '0;
    end else begin
      tok_q <= nTOK;
      bin   <= bin_nxt;
      BCID  <= bin_nxt ^ (bin_nxt >> 1);
    end
  // readout sequencer: freeze, select lowest token, read, push word, let the token settle
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      state          <= IDLE;
      frz            <= 1'b0;
      Read           <= '0;
      busy           <= 1'b0;
      col            <= '0;
      cnt            <= '0;
      dout.out_valid <= 1'b0;
      dout.out_data  <= '0;
`ifdef READOUT_TIMESTAMP_EN
      bcid_frz       <= '0;
`endif
    end else begin
      case (state)
        IDLE:
          if (EN && any_hit) begin
            state <= FRZ;
            frz   <= 1'b1;
            busy  <= 1'b1;
            cnt   <= '0;
`ifdef READOUT_TIMESTAMP_EN
            bcid_frz <= BCID;
`endif
          end
        FRZ:
          if (cnt == LAST_F) begin
            cnt   <= '0;
            state <= SEL;
          end else cnt <= cnt + 1'b1;
        SEL:
          if (any_hit) begin
            col   <= lo_col;
            Read  <= NCOL'(1) << lo_col;
            state <= RD;
          end else begin
            frz   <= 1'b0;
            state <= UNFRZ;
          end
        RD:
          if (cnt == LAST_R) begin
            cnt            <= '0;
            Read           <= '0;
            dout.out_valid <= 1'b1;
`ifdef READOUT_TIMESTAMP_EN
            dout.out_data  <= {bcid_frz, col, col_data};
`else
            dout.out_data  <= {col, col_data};
`endif
            state          <= PUSH;
          end else cnt <= cnt + 1'b1;
        PUSH:
          if (dout.out_ready) begin
            dout.out_valid <= 1'b0;
            state          <= GAP;
          end
        GAP:
          if (cnt == LAST_T) begin
            cnt   <= '0;
            state <= SEL;
          end else cnt <= cnt + 1'b1;
        UNFRZ: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule
